// File: rtl/minesweeper_pkg.sv
// rtl/minesweeper_pkg.sv - shared play-field geometry and coordinate widths
package minesweeper_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int ID_W = 32;

  localparam int DEF_X0 = 160;
  localparam int DEF_Y0 = 80;
  localparam int DEF_TILE_LOG2 = 5;
  localparam int DEF_COLS = 10;
  localparam int DEF_ROWS = 10;

  localparam logic [ID_W-1:0] NO_TILE = '0;

endpackage

// File: rtl/click_event_port_if.sv
// rtl/click_event_port_if.sv - processor-facing click record interface
interface click_event_port_if;

  logic                              pr_reset;
  logic                              nowCheck;
  logic                              pressed;
  logic [minesweeper_pkg::X_W-1:0]   x_game;
  logic [minesweeper_pkg::Y_W-1:0]   y_game;
  logic [minesweeper_pkg::ID_W-1:0]  VGAid;

  // processor side
  modport master (
    output pr_reset, nowCheck,
    input  pressed, x_game, y_game, VGAid
  );

  // peripheral side
  modport slave (
    input  pr_reset, nowCheck,
    output pressed, x_game, y_game, VGAid
  );

endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchroniser, debounce counter and press pulse
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic click
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          state;
  logic [CW-1:0] cnt;
  logic          at_limit;

  assign at_limit = (cnt == CW'(DEBOUNCE_CYCLES - 1));

  // Pulse in the cycle whose edge flips the debounced state from 0 to 1,
  // so the click lands in the buffer on that same edge.
  assign click = sync2 && !state && at_limit;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing cycles; flip the state once stable long enough
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      state <= 1'b0;
    end else if (sync2 == state) begin
      cnt <= '0;
    end else if (at_limit) begin
      state <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/click_event_port.sv
// rtl/click_event_port.sv - debounced mouse click to held two-slot click record
module click_event_port
  import minesweeper_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int X0 = DEF_X0,
  parameter int Y0 = DEF_Y0,
  parameter int TILE_LOG2 = DEF_TILE_LOG2,
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                btn_raw,
  input  logic [X_W-1:0]      cursor_x,
  input  logic [Y_W-1:0]      cursor_y,
  click_event_port_if.slave   bus,
  output logic                in_field,
  output logic [7:0]          dropped_count
);

  // Field bounds held one bit wider than the coordinates so the upper edge fits
  localparam logic [X_W:0] X_LO = (X_W + 1)'(X0);
  localparam logic [X_W:0] X_HI = (X_W + 1)'(X0 + COLS * (1 << TILE_LOG2));
  localparam logic [Y_W:0] Y_LO = (Y_W + 1)'(Y0);
  localparam logic [Y_W:0] Y_HI = (Y_W + 1)'(Y0 + ROWS * (1 << TILE_LOG2));

  logic            click;
  logic            accept;
  logic            load_phase;
  logic            front_v;
  logic [X_W-1:0]  front_x;
  logic [Y_W-1:0]  front_y;
  logic [ID_W-1:0] front_id;
  logic            skid_v;
  logic [X_W-1:0]  skid_x;
  logic [Y_W-1:0]  skid_y;
  logic [X_W-1:0]  src_x;
  logic [Y_W-1:0]  src_y;

  function automatic logic [ID_W-1:0] tile_of(input logic [X_W-1:0] x,
                                             input logic [Y_W-1:0] y);
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;
    dx = x - X_W'(X0);
    dy = y - Y_W'(Y0);
    return ID_W'(dy >> TILE_LOG2) * ID_W'(COLS) + ID_W'(dx >> TILE_LOG2) + ID_W'(1);
  endfunction

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (btn_raw),
    .click   (click)
  );

  assign in_field = ({1'b0, cursor_x} >= X_LO) && ({1'b0, cursor_x} < X_HI) &&
                    ({1'b0, cursor_y} >= Y_LO) && ({1'b0, cursor_y} < Y_HI);
  assign accept   = click && in_field;

  // A clear, or an empty FRONT while no check runs, refills FRONT from SKID
  // first and otherwise from the incoming click; both share the same update.
  assign load_phase = bus.pr_reset || (!front_v && !bus.nowCheck);
  assign src_x      = skid_v ? skid_x : cursor_x;
  assign src_y      = skid_v ? skid_y : cursor_y;

  assign bus.pressed = front_v;
  assign bus.x_game  = front_x;
  assign bus.y_game  = front_y;
  assign bus.VGAid   = front_id;

  // Two-slot click buffer with saturating drop counter
  always_ff @(posedge clock) begin
    if (reset) begin
      front_v       <= 1'b0;
      front_x       <= '0;
      front_y       <= '0;
      front_id      <= NO_TILE;
      skid_v        <= 1'b0;
      skid_x        <= '0;
      skid_y        <= '0;
      dropped_count <= '0;
    end else if (load_phase) begin
      if (skid_v || accept) begin
        front_v  <= 1'b1;
        front_x  <= src_x;
        front_y  <= src_y;
        front_id <= tile_of(src_x, src_y);
      end else begin
        front_v  <= 1'b0;
        front_id <= NO_TILE;
      end
      skid_v <= skid_v && accept;
      if (skid_v && accept) begin
        skid_x <= cursor_x;
        skid_y <= cursor_y;
      end
    end else if (!front_v || !skid_v) begin
      if (accept && !skid_v) begin
        skid_v <= 1'b1;
        skid_x <= cursor_x;
        skid_y <= cursor_y;
      end
    end else if (accept && dropped_count != 8'hFF) begin
      dropped_count <= dropped_count + 8'd1;
    end
  end

endmodule

// File: doc/click_event_port.md
Name: click_event_port

Overview:
- Peripheral-side producer for the processor's minesweeper game inputs.
- Drives `pressed`, `x_game`, `y_game` and `VGAid`.
- Consumes the processor's `pr_reset` (clear-press strobe, from the clrp instruction) and `nowCheck` (check-in-progress flag).
- Turns a raw, bouncy mouse button plus the VGA cursor position into a stable, held click record. The record persists until the processor clears it. One extra click is buffered behind it.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles (5 ms at 50 MHz) before the debounced state flips.
- X0, 160: left pixel edge of the play field.
- Y0, 80: top pixel edge of the play field.
- TILE_LOG2, 5: log2 of tile size in pixels (32 px).
- COLS, 10: tiles per row.
- ROWS, 10: tiles per column.

Ports:
- clock  in  1  master clock
- reset  in  1  synchronous, active-high reset
- btn_raw  in  1  asynchronous raw mouse button
- cursor_x  in  10  current cursor pixel x
- cursor_y  in  9  current cursor pixel y
- pr_reset  in  1  processor clear-press strobe
- nowCheck  in  1  processor check in progress
- pressed  out  1  front click record valid
- x_game  out  10  pixel x of the front click
- y_game  out  9  pixel y of the front click
- VGAid  out  32  tile id of the front click (0 = none)
- in_field  out  1  cursor currently inside the play field (combinational)
- dropped_count  out  8  saturating count of dropped clicks

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is synchronous and active-high. Every register, including those in the debouncer, clears on reset; this includes a reset arriving mid-debounce or while a record is held.
- Reset values of outputs: `pressed` = 0, `x_game` = 0, `y_game` = 0, `VGAid` = 0, `dropped_count` = 0.
- Synchroniser: `btn_raw` passes through a 2-flop synchroniser.
- Debouncer: a counter increments each cycle the synchronised value differs from the debounced state. It clears whenever they agree. When it reaches DEBOUNCE_CYCLES-1 and the values still differ, the debounced state flips at the next edge and the counter clears.
- Click event: a one-cycle pulse on the rising edge of the debounced state.
- Latency: `pressed` rises at edge DEBOUNCE_CYCLES+2 after the first edge that samples `btn_raw`=1. Counting starts at edge 1.
- Release events are ignored.
- Field check: `in_field` = (X0 <= `cursor_x` < X0+COLS·2^TILE_LOG2) and (Y0 <= `cursor_y` < Y0+ROWS·2^TILE_LOG2). Compute it in unsigned arithmetic, one bit wider than the operands.
- A click event with `in_field` = 0 is discarded and not counted as dropped.
- Accepted click: captures `cursor_x` and `cursor_y` sampled in the event cycle.
- Storage is two slots, FRONT (drives the outputs) and SKID. Next-state priority per edge:
  1. `pr_reset` = 1: FRONT <= SKID if SKID valid; else the click if one is accepted this cycle; else empty. SKID <= the click if SKID was valid and a click was accepted; else empty.
  2. FRONT empty, `nowCheck` = 0: a SKID entry promotes to FRONT. A click arriving in the same cycle goes to SKID. With no SKID entry, a click goes directly to FRONT.
  3. FRONT empty, `nowCheck` = 1: FRONT stays empty. A click goes to SKID if SKID is free.
  4. FRONT full, SKID free: a click goes to SKID.
  5. Both slots full and a click arrives (and not case 1): the click is dropped and `dropped_count` increments, saturating at 255.
- FRONT contents never change except through `pr_reset` or a load into an empty FRONT.
- Tile id: col = (x−X0)>>TILE_LOG2, row = (y−Y0)>>TILE_LOG2, id = row·COLS + col + 1.
- VGAid is computed and registered when a record enters FRONT. It is 0 whenever `pressed` = 0.
- `pr_reset` with both slots empty has no effect.

Decomposition:
- Shared package `minesweeper_pkg`: field geometry defaults (X0, Y0, TILE_LOG2, COLS, ROWS), coordinate widths (10 and 9), the tile-id width, and the NO_TILE = 0 constant.
- Sub-module `button_debounce`: synchroniser, debounce counter and rising-edge pulse. Parameter DEBOUNCE_CYCLES.
- Remaining logic stays in `click_event_port`: field check, tile-id arithmetic, two-slot buffer and drop counter.

Test Plan:
- Bench uses DEBOUNCE_CYCLES = 4.
- Hold `btn_raw` = 1 at cursor (165,85) -> `pressed` rises at edge 6, `x_game` = 165, `y_game` = 85, `VGAid` = 1.
- Toggle `btn_raw` every 2 cycles for 20 cycles, then hold it at 0 -> `pressed` never asserts, `dropped_count` = 0.
- Click at (479,399) -> `VGAid` = 100. Then click at (480,200) -> ignored, `dropped_count` unchanged.
- Three clicks at (200,100), (300,100) and (400,100) without `pr_reset` -> FRONT id 2, third click dropped, `dropped_count` = 1. Pulse `pr_reset` -> next cycle FRONT id 5, `x_game` = 300.
- With FRONT empty and `nowCheck` = 1, click at (200,100) -> `pressed` stays 0. Drop `nowCheck` -> `pressed` = 1 one edge later with id 2.
- Assert `reset` one cycle while FRONT and SKID are full and the debounce counter is mid-count -> all outputs 0 next edge. A subsequent click needs the full 6-edge latency.
